// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle component types and the ROM word unpacker.
// Related build option: TWMUL_SAT_EN (saturating output in cmult_round).
package fft_pkg;

   localparam int TW_W       = 9;
   localparam int ADDRLENGTH = 6;
   localparam int FFT_N      = 1 << ADDRLENGTH;
   localparam int ROUND_K    = 1 << (TW_W - 2);

   typedef logic signed [TW_W-1:0] tw_comp_t;

   typedef struct packed {
      tw_comp_t re;
      tw_comp_t im;
   } tw_t;

   // ROM word layout is {re, im}, each a signed TW_W-bit fraction
   function automatic tw_t tw_unpack(input logic [2*TW_W-1:0] word);
      tw_t tw;
      tw.re = tw_comp_t'(word[2*TW_W-1:TW_W]);
      tw.im = tw_comp_t'(word[TW_W-1:0]);
      return tw;
   endfunction

endpackage

// File: rtl/cmult_round.sv
// Two-stage complex multiplier with round-half-up and width reduction.
// Stage A registers the four partial products, stage B the rounded result.
// Build option TWMUL_SAT_EN: saturate on overflow instead of wrapping.
module cmult_round #(
   parameter int WIDTH = 16,
   parameter int TW_W  = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] a_re,
   input  logic signed [WIDTH-1:0] a_im,
   input  logic signed [TW_W-1:0]  w_re,
   input  logic signed [TW_W-1:0]  w_im,
   input  logic                    in_valid,
   input  logic                    in_sof,
   output logic signed [WIDTH-1:0] y_re,
   output logic signed [WIDTH-1:0] y_im,
   output logic                    out_valid,
   output logic                    out_sof
);

   localparam int PW = WIDTH + TW_W;
   localparam int SW = PW + 1;
   localparam logic signed [SW-1:0] RND = SW'(1 << (TW_W - 2));

   logic signed [PW-1:0]    pr_q, pr_d, pi_q, pi_d, qr_q, qr_d, qi_q, qi_d;
   logic                    v3_q, v3_d, sof3_q, sof3_d;
   logic signed [SW-1:0]    sr, si, rnd_re, rnd_im;
   logic signed [WIDTH-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
   logic                    v4_q, v4_d, sof4_q, sof4_d;

`ifdef TWMUL_SAT_EN
   // Clamp to the signed WIDTH-bit range when the upper bits are not pure sign
   function automatic logic signed [WIDTH-1:0] fit(input logic signed [SW-1:0] v);
      logic [SW-WIDTH:0] hi;
      hi = v[SW-1:WIDTH-1];
      if (hi == '0 || hi == '1)
         fit = v[WIDTH-1:0];
      else if (v[SW-1])
         fit = {1'b1, {(WIDTH-1){1'b0}}};
      else
         fit = {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`else
   logic unused_rnd_hi;
   assign unused_rnd_hi = ^{rnd_re[SW-1:WIDTH], rnd_im[SW-1:WIDTH]};
`endif

   // Partial products, then cross sums, rounding and reduction
   always_comb begin
      pr_d   = PW'(a_re) * PW'(w_re);
      pi_d   = PW'(a_im) * PW'(w_im);
      qr_d   = PW'(a_re) * PW'(w_im);
      qi_d   = PW'(a_im) * PW'(w_re);
      v3_d   = in_valid;
      sof3_d = in_sof;

      sr     = SW'(pr_q) - SW'(pi_q);
      si     = SW'(qr_q) + SW'(qi_q);
      rnd_re = (sr + RND) >>> (TW_W - 1);
      rnd_im = (si + RND) >>> (TW_W - 1);
`ifdef TWMUL_SAT_EN
      y_re_d = fit(rnd_re);
      y_im_d = fit(rnd_im);
`else
      y_re_d = rnd_re[WIDTH-1:0];
      y_im_d = rnd_im[WIDTH-1:0];
`endif
      v4_d   = v3_q;
      sof4_d = sof3_q;
   end

   // Product and result registers; only the qualifiers need a known reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pr_q   <= '0;
         pi_q   <= '0;
         qr_q   <= '0;
         qi_q   <= '0;
         v3_q   <= 1'b0;
         sof3_q <= 1'b0;
         y_re_q <= '0;
         y_im_q <= '0;
         v4_q   <= 1'b0;
         sof4_q <= 1'b0;
      end else begin
         pr_q   <= pr_d;
         pi_q   <= pi_d;
         qr_q   <= qr_d;
         qi_q   <= qi_d;
         v3_q   <= v3_d;
         sof3_q <= sof3_d;
         y_re_q <= y_re_d;
         y_im_q <= y_im_d;
         v4_q   <= v4_d;
         sof4_q <= sof4_d;
      end
   end

   assign y_re      = y_re_q;
   assign y_im      = y_im_q;
   assign out_valid = v4_q;
   assign out_sof   = sof4_q;

endmodule

// File: rtl/fft_twiddle_mul.sv
// Streaming twiddle multiplier: sequences the twiddle ROM address from a
// per-symbol sample counter, delays the sample to meet the registered ROM
// read, and hands both to cmult_round. Four register stages in total.
// Build option TWMUL_SAT_EN: saturating output (see cmult_round).
module fft_twiddle_mul
   import fft_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int TW_W       = fft_pkg::TW_W,
   parameter int ADDRLENGTH = fft_pkg::ADDRLENGTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] din_re,
   input  logic signed [WIDTH-1:0] din_im,
   input  logic                    din_valid,
   input  logic                    din_sof,
   output logic [ADDRLENGTH-1:0]   ROM_addr,
   input  logic [2*TW_W-1:0]       ROM_data,
   output logic signed [WIDTH-1:0] dout_re,
   output logic signed [WIDTH-1:0] dout_im,
   output logic                    dout_valid,
   output logic                    dout_sof
);

   logic [ADDRLENGTH-1:0]   idx_q, idx_d, addr_q, addr_d, addr_a;
   logic signed [WIDTH-1:0] re1_q, re1_d, im1_q, im1_d;
   logic signed [WIDTH-1:0] re2_q, re2_d, im2_q, im2_d;
   logic                    v1_q, v1_d, sof1_q, sof1_d;
   logic                    v2_q, v2_d, sof2_q, sof2_d;
   logic signed [TW_W-1:0]  tw_re, tw_im;

   // Address sequencing and the two alignment stages ahead of the multiplier
   always_comb begin
      addr_a = din_sof ? '0 : idx_q;
      idx_d  = idx_q;
      addr_d = addr_q;
      if (din_valid) begin
         addr_d = addr_a;
         idx_d  = addr_a + ADDRLENGTH'(1);
      end
      re1_d  = din_re;
      im1_d  = din_im;
      v1_d   = din_valid;
      sof1_d = din_valid & din_sof;
      re2_d  = re1_q;
      im2_d  = im1_q;
      v2_d   = v1_q;
      sof2_d = sof1_q;
      tw_re  = $signed(ROM_data[2*TW_W-1:TW_W]);
      tw_im  = $signed(ROM_data[TW_W-1:0]);
   end

   // Counter, ROM address and S1/S2 pipeline registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= '0;
         addr_q <= '0;
         re1_q  <= '0;
         im1_q  <= '0;
         v1_q   <= 1'b0;
         sof1_q <= 1'b0;
         re2_q  <= '0;
         im2_q  <= '0;
         v2_q   <= 1'b0;
         sof2_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         addr_q <= addr_d;
         re1_q  <= re1_d;
         im1_q  <= im1_d;
         v1_q   <= v1_d;
         sof1_q <= sof1_d;
         re2_q  <= re2_d;
         im2_q  <= im2_d;
         v2_q   <= v2_d;
         sof2_q <= sof2_d;
      end
   end

   assign ROM_addr = addr_q;

   cmult_round #(
      .WIDTH (WIDTH),
      .TW_W  (TW_W)
   ) u_cmult (
      .clk       (clk),
      .rst       (rst),
      .a_re      (re2_q),
      .a_im      (im2_q),
      .w_re      (tw_re),
      .w_im      (tw_im),
      .in_valid  (v2_q),
      .in_sof    (sof2_q),
      .y_re      (dout_re),
      .y_im      (dout_im),
      .out_valid (dout_valid),
      .out_sof   (dout_sof)
   );

endmodule

// File: tb/tb_fft_twiddle_mul.sv
// Bench for fft_twiddle_mul: registered ROM model, per-sample reference
// computed with plain integer arithmetic, directed and random stimulus.
// Honors TWMUL_SAT_EN to pick saturating or wrapping expectations.
module tb_fft_twiddle_mul;

   localparam int WIDTH = 16;
   localparam int TW_W  = 9;
   localparam int AL    = 6;
   localparam int N     = 1 << AL;

   logic                    clk = 1'b0;
   logic                    rst;
   logic signed [WIDTH-1:0] din_re, din_im;
   logic                    din_valid, din_sof;
   logic [AL-1:0]           ROM_addr;
   logic [2*TW_W-1:0]       ROM_data;
   logic signed [WIDTH-1:0] dout_re, dout_im;
   logic                    dout_valid, dout_sof;

   logic signed [TW_W-1:0]  rom_re [N];
   logic signed [TW_W-1:0]  rom_im [N];

   typedef struct {
      bit v;
      bit sof;
      int re;
      int im;
   } exp_t;

   exp_t pipe [4];
   int   idx_m;
   int   addr_m;
   int   n_chk  = 0;
   int   n_pass = 0;

   fft_twiddle_mul dut (
      .clk        (clk),
      .rst        (rst),
      .din_re     (din_re),
      .din_im     (din_im),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .ROM_addr   (ROM_addr),
      .ROM_data   (ROM_data),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .dout_valid (dout_valid),
      .dout_sof   (dout_sof)
   );

   always #5 clk = ~clk;

   // twiddle ROM with one-cycle registered read
   always @(posedge clk) ROM_data <= {rom_re[ROM_addr], rom_im[ROM_addr]};

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // round half-up to integer units of 1/256, then fit to 16 bits
   function automatic int reduce(input longint v);
      longint r;
      logic [15:0] low;
      r = v + 128;
      r = (r >= 0) ? (r / 256) : -((-r + 255) / 256);
`ifdef TWMUL_SAT_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      return int'(r);
`else
      low = r[15:0];
      return int'($signed(low));
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) pipe[i] = '{0, 0, 0, 0};
      idx_m  = 0;
      addr_m = 0;
   endtask

   // drive one sample slot, advance a clock, check address and output
   task automatic step(input bit v, input bit s, input int re, input int im);
      exp_t   e;
      int     a, twr, twi;
      longint sr, si;
      din_valid = v;
      din_sof   = s;
      din_re    = 16'(re);
      din_im    = 16'(im);
      e = '{0, 0, 0, 0};
      if (v) begin
         a      = s ? 0 : idx_m;
         idx_m  = (a + 1) % N;
         addr_m = a;
         twr    = rom_re[a];
         twi    = rom_im[a];
         sr     = longint'(re) * twr - longint'(im) * twi;
         si     = longint'(re) * twi + longint'(im) * twr;
         e      = '{1, s, reduce(sr), reduce(si)};
      end
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e;
      @(posedge clk);
      #1;
      chk("rom_addr", ROM_addr, addr_m);
      chk("dout_valid", dout_valid, pipe[3].v);
      if (pipe[3].v) begin
         chk("dout_sof", dout_sof, pipe[3].sof);
         chk("dout_re", dout_re, pipe[3].re);
         chk("dout_im", dout_im, pipe[3].im);
      end
   endtask

   task automatic flush(input int n);
      repeat (n) step(0, 0, 0, 0);
   endtask

   task automatic rand_sample(output int re, output int im);
      logic [15:0] r16;
      r16 = 16'($urandom);
      re  = int'($signed(r16));
      r16 = 16'($urandom);
      im  = int'($signed(r16));
   endtask

   initial begin
      int re, im;
      rst       = 1'b1;
      din_valid = 1'b0;
      din_sof   = 1'b0;
      din_re    = '0;
      din_im    = '0;
      for (int i = 0; i < N; i++) begin
         rom_re[i] = 9'(255);
         rom_im[i] = 9'(0);
      end
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rom_addr", ROM_addr, 0);
      chk("rst_dout_re", dout_re, 0);
      chk("rst_dout_im", dout_im, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout_sof", dout_sof, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // unity twiddle: full symbol of (1000, -500)
      for (int i = 0; i < N; i++) step(1, i == 0, 1000, -500);
      flush(5);

      // quarter rotation at address 5 and rounding of small negative products
      rom_re[5] = 9'(0);    rom_im[5] = 9'(-255);
      rom_re[6] = 9'(-1);   rom_im[6] = 9'(0);
      rom_re[7] = 9'(-1);   rom_im[7] = 9'(0);
      rom_re[8] = 9'(-3);   rom_im[8] = 9'(1);
      for (int i = 0; i < 5; i++) step(1, i == 0, 256, 0);
      step(1, 0, 256, 0);
      step(1, 0, 128, 0);
      step(1, 0, 129, 0);
      step(1, 0, 85, -43);
      flush(5);

      // addressing: 70 consecutive, finish symbol, then a mid-symbol restart
      for (int i = 0; i < 70; i++) step(1, i == 0, i * 100, -i * 37);
      for (int i = 0; i < 58; i++) step(1, 0, 500, 600);
      for (int i = 0; i < 20; i++) step(1, i == 0, -700, 300);
      for (int i = 0; i < 10; i++) step(1, i == 0, 1234, -4321);
      flush(5);

      // bubbles: valid pattern 1,0,0,1 with random data and twiddles
      for (int i = 0; i < N; i++) begin
         rom_re[i] = 9'($urandom);
         rom_im[i] = 9'($urandom);
      end
      for (int i = 0; i < 24; i++) begin
         rand_sample(re, im);
         step((i % 4 == 0) || (i % 4 == 3), i == 0, re, im);
      end
      flush(5);

      // overflow: 255 - j256 at address 0
      rom_re[0] = 9'(255);
      rom_im[0] = 9'(-256);
      step(1, 1, 32767, 32767);
      step(1, 1, -32768, -32768);
      step(1, 1, 32767, -32768);
      flush(5);

      // random traffic: random valid, occasional sof, random ROM content
      for (int i = 0; i < N; i++) begin
         rom_re[i] = 9'($urandom);
         rom_im[i] = 9'($urandom);
      end
      for (int i = 0; i < 400; i++) begin
         rand_sample(re, im);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, re, im);
      end
      flush(5);

      // asynchronous reset with three samples in flight
      for (int i = 0; i < 5; i++) step(1, i == 0, 2000 + i, -3000 - i);
      for (int i = 0; i < 3; i++) step(1, 0, 111, 222);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rom_addr", ROM_addr, 0);
      chk("arst_dout_re", dout_re, 0);
      chk("arst_dout_im", dout_im, 0);
      chk("arst_dout_valid", dout_valid, 0);
      chk("arst_dout_sof", dout_sof, 0);
      din_valid = 1'b0;
      din_sof   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_model();
      step(1, 0, 4000, -4000);
      for (int i = 0; i < 3; i++) step(1, 0, 10 * i, 7 * i);
      flush(6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
